// File: rtl/addsub16_delta_if.sv
// Stream interface for addsub16_delta.
// Carries accumulator samples in and recovered {ERR, ZERO, SET, DATA} steps out.
interface addsub16_delta_if #(
   parameter int unsigned FIFO_DEPTH = 4
) ();
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [15:0]   din_i;
   logic          din_vld_i;
   logic          din_rdy_o;
   logic [15:0]   data_o;
   logic          set_o;
   logic          err_o;
   logic          zero_o;
   logic          dout_vld_o;
   logic          dout_rdy_i;
   logic [CW-1:0] count_o;

   modport slave (
      input  din_i, din_vld_i, dout_rdy_i,
      output din_rdy_o, data_o, set_o, err_o, zero_o, dout_vld_o, count_o
   );

   modport master (
      output din_i, din_vld_i, dout_rdy_i,
      input  din_rdy_o, data_o, set_o, err_o, zero_o, dout_vld_o, count_o
   );
endinterface

// File: rtl/addsub16_delta.sv
// Recovers {magnitude, direction} steps from a stream of 16-bit up/down accumulator values.
// One compute register feeds a small FIFO; the staged entry counts toward occupancy.
module addsub16_delta #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [15:0] MAX_STEP   = 16'h7FFF
) (
   input logic              clk,
   input logic              rst_n,
   input logic              en_i,
   input logic              clr_i,
   addsub16_delta_if.slave  bus
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic        err;
      logic        zero;
      logic        set;
      logic [15:0] data;
   } entry_t;

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q, state_d;
   logic [15:0]   ref_q, ref_d;
   entry_t        stg_q, stg_d;
   logic          stg_vld_q, stg_vld_d;
   entry_t        mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] fcnt_q, fcnt_d;
   logic [CW-1:0] count_q, count_d;
   logic          din_rdy_q, din_rdy_d;
   logic          dout_vld_q, dout_vld_d;

   logic          accept;
   logic          pop;
   logic          push;
   logic [15:0]   diff;
   logic [15:0]   mag;
   entry_t        step;
   entry_t        head;

   assign accept = bus.din_vld_i & din_rdy_q & en_i;
   assign pop    = dout_vld_q & bus.dout_rdy_i;

   // Modular difference handles wrap; 16'h8000 has no signed magnitude, so it is flagged.
   always_comb begin
      diff      = bus.din_i - ref_q;
      mag       = diff[15] ? 16'(~diff + 16'd1) : diff;
      step.set  = diff[15];
      step.data = mag;
      step.zero = (diff == 16'h0000);
      step.err  = (diff == 16'h8000) | (mag > MAX_STEP);
   end

   always_comb begin
      state_d = state_q;
      ref_d   = ref_q;
      push    = 1'b0;
      if (clr_i) begin
         state_d = IDLE;
      end else if (accept) begin
         ref_d = bus.din_i;
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     push    = 1'b1;
            default: state_d = IDLE;
         endcase
      end
   end

   // Staged entry always finds room: total occupancy never exceeds FIFO_DEPTH.
   always_comb begin
      stg_vld_d  = push;
      stg_d      = push ? step : stg_q;
      wr_ptr_d   = wr_ptr_q + AW'(stg_vld_q);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      fcnt_d     = fcnt_q + CW'(stg_vld_q) - CW'(pop);
      count_d    = fcnt_d + CW'(stg_vld_d);
      din_rdy_d  = (count_d < CW'(FIFO_DEPTH));
      dout_vld_d = (fcnt_d != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ref_q      <= '0;
         stg_q      <= '0;
         stg_vld_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fcnt_q     <= '0;
         count_q    <= '0;
         din_rdy_q  <= 1'b0;
         dout_vld_q <= 1'b0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         ref_q      <= ref_d;
         stg_q      <= stg_d;
         stg_vld_q  <= stg_vld_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fcnt_q     <= fcnt_d;
         count_q    <= count_d;
         din_rdy_q  <= din_rdy_d;
         dout_vld_q <= dout_vld_d;
         if (stg_vld_q) mem_q[wr_ptr_q] <= stg_q;
      end
   end

   assign head           = mem_q[rd_ptr_q];
   assign bus.data_o     = head.data;
   assign bus.set_o      = head.set;
   assign bus.err_o      = head.err;
   assign bus.zero_o     = head.zero;
   assign bus.dout_vld_o = dout_vld_q;
   assign bus.din_rdy_o  = din_rdy_q;
   assign bus.count_o    = count_q;
endmodule

// File: tb/tb_addsub16_delta.sv
// Self-checking bench for addsub16_delta: vector table, scoreboard queue, hand sequences.
module tb_addsub16_delta;
   typedef struct packed {
      logic        err;
      logic        zero;
      logic        set;
      logic [15:0] data;
   } entry_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      entry_t      exp;
   } vec_t;

   logic clk;
   logic rst_n;
   logic en, clr;
   logic en2, clr2;

   int checks   = 0;
   int failures = 0;

   entry_t      q[$];
   bit          m_run;
   logic [15:0] m_ref;

   addsub16_delta_if #(.FIFO_DEPTH(4)) bus ();
   addsub16_delta_if #(.FIFO_DEPTH(4)) bus2 ();

   addsub16_delta #(.FIFO_DEPTH(4), .MAX_STEP(16'h7FFF)) dut (
      .clk(clk), .rst_n(rst_n), .en_i(en), .clr_i(clr), .bus(bus)
   );

   addsub16_delta #(.FIFO_DEPTH(4), .MAX_STEP(16'h0010)) dut2 (
      .clk(clk), .rst_n(rst_n), .en_i(en2), .clr_i(clr2), .bus(bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic entry_t model_step(input logic [15:0] r, input logic [15:0] v);
      entry_t e;
      int d, m;
      d = int'(v) - int'(r);
      if (d < 0) d += 65536;
      if (d >= 32768) d -= 65536;
      m = (d < 0) ? -d : d;
      e.set  = (d < 0);
      e.data = 16'(m);
      e.zero = (d == 0);
      e.err  = (m > 32767);
      return e;
   endfunction

   task automatic model_accept(input logic [15:0] v, input bit has_exp, input entry_t exp);
      if (!m_run) begin
         m_run = 1'b1;
      end else begin
         q.push_back(has_exp ? exp : model_step(m_ref, v));
      end
      m_ref = v;
   endtask

   task automatic send(input logic [15:0] v, input bit has_exp, input entry_t exp);
      bit ok = 1'b0;
      bus.din_i     = v;
      bus.din_vld_i = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.din_rdy_o && en) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: din_rdy=%0b, required 1", bus.din_rdy_o);
         bus.din_vld_i = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.din_vld_i = 1'b0;
      model_accept(v, has_exp, exp);
   endtask

   task automatic clr_pulse();
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr   = 1'b0;
      m_run = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (q.size() == 0 && bus.count_o == 0 && !bus.dout_vld_o) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: queue=%0d count=%0d, required 0/0", nm, q.size(), bus.count_o);
      end
   endtask

   // Scoreboard: compare the head on the half-cycle before it is popped.
   always @(negedge clk) begin
      if (rst_n && bus.dout_vld_o && bus.dout_rdy_i) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out: got %0h, required none",
                     {bus.err_o, bus.zero_o, bus.set_o, bus.data_o});
         end else begin
            chk("dout", 32'({bus.err_o, bus.zero_o, bus.set_o, bus.data_o}), 32'(q.pop_front()));
         end
      end
   end

   initial begin
      vec_t   tbl [7];
      entry_t none;
      none = '0;

      tbl[0] = '{16'hFFFE, 16'h0003, '{1'b0, 1'b0, 1'b0, 16'h0005}};
      tbl[1] = '{16'h0003, 16'hFFFE, '{1'b0, 1'b0, 1'b1, 16'h0005}};
      tbl[2] = '{16'h0000, 16'h8000, '{1'b1, 1'b0, 1'b1, 16'h8000}};
      tbl[3] = '{16'h1234, 16'h1234, '{1'b0, 1'b1, 1'b0, 16'h0000}};
      tbl[4] = '{16'h0000, 16'h7FFF, '{1'b0, 1'b0, 1'b0, 16'h7FFF}};
      tbl[5] = '{16'h7FFF, 16'h0000, '{1'b0, 1'b0, 1'b1, 16'h7FFF}};
      tbl[6] = '{16'h0000, 16'h8001, '{1'b0, 1'b0, 1'b1, 16'h7FFF}};

      m_run = 1'b0;
      m_ref = '0;
      en = 1'b1; clr = 1'b0; en2 = 1'b1; clr2 = 1'b0;
      bus.din_i = '0;  bus.din_vld_i = 1'b0;  bus.dout_rdy_i = 1'b1;
      bus2.din_i = '0; bus2.din_vld_i = 1'b0; bus2.dout_rdy_i = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;

      repeat (3) @(posedge clk);
      #3;
      chk("rst_din_rdy",  32'(bus.din_rdy_o),  0);
      chk("rst_dout_vld", 32'(bus.dout_vld_o), 0);
      chk("rst_count",    32'(bus.count_o),    0);
      chk("rst_head",     32'({bus.err_o, bus.zero_o, bus.set_o, bus.data_o}), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rdy_after_rst", 32'(bus.din_rdy_o), 1);

      // Reduced MAX_STEP instance: 0000 -> 0011 -> 0021.
      bus2.din_vld_i = 1'b1;
      bus2.din_i = 16'h0000; @(posedge clk); #1;
      bus2.din_i = 16'h0011; @(posedge clk); #1;
      bus2.din_i = 16'h0021; @(posedge clk); #1;
      bus2.din_vld_i = 1'b0;
      @(posedge clk); #1;
      chk("max_count", 32'(bus2.count_o), 2);
      chk("max_over",  32'({bus2.err_o, bus2.zero_o, bus2.set_o, bus2.data_o}), 32'h40011);
      bus2.dout_rdy_i = 1'b1;
      @(posedge clk); #1;
      bus2.dout_rdy_i = 1'b0;
      chk("max_limit", 32'({bus2.err_o, bus2.zero_o, bus2.set_o, bus2.data_o}), 32'h00010);
      chk("max_count1", 32'(bus2.count_o), 1);

      // Basic stream and first-output latency.
      send(16'h0007, 1'b0, none);
      send(16'h0009, 1'b1, '{1'b0, 1'b0, 1'b0, 16'h0002});
      chk("lat_edge1", 32'(bus.dout_vld_o), 0);
      @(posedge clk); #1;
      chk("lat_edge2", 32'(bus.dout_vld_o), 1);
      send(16'h0004, 1'b1, '{1'b0, 1'b0, 1'b1, 16'h0005});
      send(16'h0004, 1'b1, '{1'b0, 1'b1, 1'b0, 16'h0000});
      wait_drain("drain_basic");

      // Table of isolated pairs.
      for (int i = 0; i < 7; i++) begin
         clr_pulse();
         send(tbl[i].a, 1'b0, none);
         send(tbl[i].b, 1'b1, tbl[i].exp);
      end
      wait_drain("drain_table");

      // CLR wins over a simultaneous accept.
      clr_pulse();
      send(16'h0040, 1'b0, none);
      bus.din_i = 16'h0050; bus.din_vld_i = 1'b1; clr = 1'b1;
      @(posedge clk); #1;
      bus.din_vld_i = 1'b0; clr = 1'b0; m_run = 1'b0;
      send(16'h0060, 1'b0, none);
      send(16'h0065, 1'b1, '{1'b0, 1'b0, 1'b0, 16'h0005});
      wait_drain("drain_clr");

      // EN low blocks acceptance.
      en = 1'b0; bus.din_i = 16'h0070; bus.din_vld_i = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("en_count", 32'(bus.count_o), 0);
      bus.din_vld_i = 1'b0; en = 1'b1;
      send(16'h0066, 1'b0, none);
      wait_drain("drain_en");

      // Back-pressure with distinct steps to expose ordering.
      bus.dout_rdy_i = 1'b0;
      clr_pulse();
      send(16'h0100, 1'b0, none);
      send(16'h0101, 1'b0, none);
      send(16'h0103, 1'b0, none);
      send(16'h0106, 1'b0, none);
      send(16'h010A, 1'b0, none);
      bus.din_i = 16'h010F; bus.din_vld_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("full_count",   32'(bus.count_o),   4);
      chk("full_din_rdy", 32'(bus.din_rdy_o), 0);
      bus.dout_rdy_i = 1'b1;
      @(posedge clk); #1;
      chk("pop_din_rdy", 32'(bus.din_rdy_o), 1);
      chk("pop_count",   32'(bus.count_o),   3);
      @(posedge clk); #1;
      bus.din_vld_i = 1'b0;
      model_accept(16'h010F, 1'b0, none);
      wait_drain("drain_bp");

      // Asynchronous reset with pending entries.
      bus.dout_rdy_i = 1'b0;
      clr_pulse();
      send(16'h0300, 1'b0, none);
      send(16'h0301, 1'b0, none);
      send(16'h0302, 1'b0, none);
      send(16'h0303, 1'b0, none);
      repeat (2) @(posedge clk);
      #1;
      chk("pre_rst_count", 32'(bus.count_o), 3);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_vld",   32'(bus.dout_vld_o), 0);
      chk("mid_rst_count", 32'(bus.count_o),    0);
      q.delete();
      m_run = 1'b0;
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      bus.dout_rdy_i = 1'b1;
      send(16'h0400, 1'b0, none);
      send(16'h0405, 1'b1, '{1'b0, 1'b0, 1'b0, 16'h0005});
      wait_drain("drain_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/addsub16_delta.md
Name: addsub16_delta

Overview:
- Inverse of the ADDSUB16 up/down accumulator: consumes the stream of 16-bit running-sum values and recovers each step as a magnitude (DATA) plus direction (SET: 0 = add, 1 = subtract).
- Sits downstream of the accumulator for checking and replay.
- Valid/ready handshake on both sides, with a small output FIFO to absorb back-pressure.

Parameters:
- FIFO_DEPTH, 4: output FIFO entries; power of two, minimum 2.
- MAX_STEP, 16'h7FFF: largest legal step magnitude; a larger magnitude raises ERR.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous active-low reset.
- EN  input  1  global enable; when 0, no input is accepted, FSM holds, output side still drains.
- CLR  input  1  synchronous; discards the reference sample and returns the FSM to IDLE; FIFO contents kept.
- DIN  input  16  accumulator value.
- DIN_VLD  input  1  DIN is valid.
- DIN_RDY  output  1  block can accept DIN.
- DATA  output  16  recovered step magnitude.
- SET  output  1  recovered direction: 0 = add, 1 = subtract.
- ERR  output  1  magnitude > MAX_STEP, or ambiguous 16'h8000 step.
- ZERO  output  1  step was zero.
- DOUT_VLD  output  1  FIFO head is valid.
- DOUT_RDY  input  1  consumer takes the FIFO head.
- COUNT  output  log2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (RST=0, asynchronous):
  - FSM enters IDLE; reference register = 0; FIFO empty.
  - Outputs: DIN_RDY=0, DOUT_VLD=0, COUNT=0, DATA=0, SET=0, ERR=0, ZERO=0.
  - DIN_RDY goes to 1 on the first CLK edge after RST deasserts.
- Accept: a sample is accepted when DIN_VLD & DIN_RDY & EN at a rising edge.
  - DIN_RDY = (COUNT < FIFO_DEPTH), registered.
  - No combinational path from DOUT_RDY to DIN_RDY.
- FSM states IDLE, RUN:
  - IDLE, accept: DIN goes to the reference register; go to RUN; nothing pushed.
  - RUN, accept: compute the step, push one entry, reference <= DIN.
  - CLR=1: go to IDLE next edge; CLR wins over a simultaneous accept (sample dropped).
- Arithmetic (RUN), with d = (DIN - ref) mod 2^16:
  - d[15]=0: SET=0, DATA=d.
  - d[15]=1: SET=1, DATA=(~d+1)[15:0].
  - d=16'h0000: SET=0, DATA=0, ZERO=1.
  - d=16'h8000: SET=1, DATA=16'h8000, ERR=1.
  - ERR=1 whenever DATA > MAX_STEP.
  - Wrap-around is handled by the modular subtract: FFFE to 0003 is +5.
- FIFO:
  - Entry = {ERR, ZERO, SET, DATA}, 19 bits.
  - Outputs DATA/SET/ERR/ZERO show the FIFO head whenever DOUT_VLD=1; values are undefined-but-stable when empty.
  - Pop when DOUT_VLD & DOUT_RDY.
- Latency: sample accepted at edge N into an empty FIFO gives DOUT_VLD=1 after edge N+1 (one register stage plus FIFO write), i.e. 2 edges from accept to head.
  - Compute register stage counts toward occupancy, so COUNT never exceeds FIFO_DEPTH.
- Simultaneous push and pop: COUNT unchanged; ordering preserved.
- Full: DIN_RDY=0, DIN held by the upstream; a pop in cycle N raises DIN_RDY at edge N+1.
- Empty with DOUT_RDY=1: no pop; COUNT stays 0.
- Reset mid-operation: all state cleared immediately; pending FIFO entries lost.

Test Plan:
- Release reset, then send DIN 0007, 0009, 0004, 0004 with DOUT_RDY=1 → three outputs:
  - {SET=0, DATA=0002}
  - {SET=1, DATA=0005}
  - {SET=0, DATA=0000, ZERO=1}
  - DOUT_VLD first rises 2 edges after the 0009 accept.
- Wrap-around: DIN FFFE then 0003 → SET=0, DATA=0005. Then 0003 then FFFE → SET=1, DATA=0005. ERR=0 for both.
- Ambiguous and limit cases:
  - DIN 0000 then 8000 → SET=1, DATA=8000, ERR=1.
  - With MAX_STEP=0010: 0000 then 0011 → ERR=1; 0011 then 0021 → ERR=0.
- Back-pressure (FIFO_DEPTH=4):
  - DOUT_RDY=0, stream six increasing samples → COUNT reaches 4 and DIN_RDY drops; the source holds its current sample.
  - Then DOUT_RDY=1 → five entries drain in order, with DIN_RDY returning one edge after the first pop.
- CLR and EN:
  - Assert CLR together with DIN=0050 → no output; next sample 0060 becomes the reference only; following sample 0065 → DATA=0005.
  - EN=0 during DIN_VLD=1 → nothing accepted.
- Reset mid-stream: pull RST low with 3 FIFO entries pending → DOUT_VLD=0 and COUNT=0 immediately, without waiting for a clock edge; after release, the first sample only primes.
